eth_tx_crc_fifo: RTL and testbench
==================================

# eth_tx_crc_fifo

Payload buffer and frame-check engine for the GMII UDP transmitter. A show-ahead dual-clock byte FIFO carries payload from the producer clock `wrclk` into the GMII transmit clock `GMII_GTXC`. A byte-wide Ethernet CRC-32 engine, running on `GMII_GTXC`, accumulates every transmitted frame byte from destination MAC through the last payload byte. It presents the FCS already byte-ordered for transmission, most-significant byte first.

## Interface
Parameters:
- `DEPTH`, default 4096: FIFO capacity in bytes; must be a power of two and at most 4096.
- `UW`, default 13: width of the used-word counters.

Ports:
- `GMII_GTXC`  in  1: read-side and CRC clock.
- `wrclk`  in  1: write-side clock.
- `Rst_n`  in  1: reset, asynchronous, active-low.
- `aclr`  in  1: asynchronous FIFO clear, active-high, same effect on the FIFO as `Rst_n`.
- `wrreq`  in  1: write strobe, sampled on `wrclk`.
- `wrdata`  in  8: write byte.
- `wrusedw`  out  UW: occupancy as seen by the write side.
- `wrfull`  out  1: FIFO full, write side.
- `rdreq`  in  1: read/advance strobe, sampled on `GMII_GTXC`.
- `q`  out  8: head byte (show-ahead).
- `rdusedw`  out  UW: occupancy as seen by the read side.
- `rdempty`  out  1: FIFO empty, read side.
- `Reset`  in  1: synchronous CRC re-initialise, active-high.
- `Enable`  in  1: CRC accumulate enable.
- `Data_in`  in  8: CRC input byte.
- `Crc`  out  32: CRC state register.
- `CrcNext`  out  32: next state, i.e. `Crc` updated with `Data_in`.
- `Crc_eth`  out  32: FCS to transmit.

## Operation
FIFO:
- Memory is `DEPTH`×8 bits.
- Binary read/write pointers carry one extra wrap bit.
- Gray-coded copies of each pointer cross into the other domain through two-flop synchronisers.
- A write when `wrreq`=1 and `wrfull`=0 stores `wrdata`. A write while full is ignored; contents are unchanged.
- Show-ahead: `q` always shows the oldest unread byte while `rdempty`=0.
- A read when `rdreq`=1 and `rdempty`=0 pops that byte; `q` shows the next byte after the same edge.
- A read while empty is ignored and `q` holds its last value.
- `rdusedw` = wptr_sync − rptr; `wrusedw` = wptr − rptr_sync. Both are modulo 2·DEPTH and range 0..DEPTH.
- Simultaneous read and write are both honoured.

CRC:
- Reflected CRC-32: polynomial 0xEDB88320, state initialised to 0xFFFFFFFF.
- Each byte is processed LSB first, i.e. 8 serial steps per byte, unrolled into one combinational stage.
- `CrcNext` is that update applied to `Crc` and `Data_in`; it is independent of `Enable`.
- Clock edge priority: `Reset`=1 sets `Crc` to 0xFFFFFFFF; otherwise `Enable`=1 loads `CrcNext`; otherwise `Crc` holds.
- Define S = `Enable` ? `CrcNext` : `Crc`, and C = ~S. Then `Crc_eth` = {C[7:0], C[15:8], C[23:16], C[31:24]}.
- Because of the `Enable` selection, `Crc_eth` already includes a byte presented with `Enable` high, before that byte is registered.

## Timing
- Reset, `Rst_n`=0:
  - `Crc` = 0xFFFFFFFF.
  - All pointers and synchronisers = 0.
  - `rdusedw` = `wrusedw` = 0, `rdempty` = 1, `wrfull` = 0, `q` = 0x00.
- `aclr`=1 resets the FIFO identically but leaves `Crc` untouched.
- Reset asserted mid-operation discards all FIFO contents at once.
- Write-side latency:
  - `wrusedw` and `wrfull` reflect a write on the next `wrclk` edge.
  - `rdusedw` and `rdempty` reflect it 2–3 `GMII_GTXC` edges later.
- Read-side latency mirrors the write side: `rdusedw` and `rdempty` update on the next `GMII_GTXC` edge; `wrusedw` and `wrfull` update 2–3 `wrclk` edges later.
- Full/empty flags are conservative and never falsely deasserted.
- `Crc`, `CrcNext` and `Crc_eth` have zero combinational latency relative to `Data_in`, `Enable` and the register state.
- Intended FCS transmission sequence:
  - The last payload byte is presented with `Enable`=1, and `Crc_eth[31:24]` is sampled on the same edge.
  - `Enable` then drops, so `Crc` freezes.
  - `Crc_eth[23:16]`, `[15:8]` and `[7:0]` are taken on the following three edges.

## Test plan
- Reset, then `Enable`=1 for the bytes "123456789" (0x31..0x39) -> after the 9th edge, `Enable`=0 and `Crc_eth` = 0x2639F4CB.
- The same frame followed by its FCS bytes 0x26, 0x39, 0xF4, 0xCB -> `Crc` = 0xDEBB20E3 (the residue).
- `Reset`=1 for one edge mid-frame -> `Crc` = 0xFFFFFFFF, and `Crc_eth` = 0x00000000 with `Enable`=0.
- Write 0x00..0x0F at 125 MHz `wrclk` while `GMII_GTXC` = 100 MHz:
  - `rdempty` falls within 3 read edges.
  - `q` = 0x00 before any `rdreq`.
  - Sixteen `rdreq` edges yield 0x00..0x0F in order.
  - `rdempty` then equals 1 and `rdusedw` = 0.
- Fill with DEPTH writes -> `wrfull`=1 and `wrusedw` = DEPTH. A further write is ignored, and read-back shows no corruption.
- `aclr` pulse with 100 bytes buffered -> both used-word counts are 0 and `rdempty`=1 immediately, while `Crc` is unchanged.

Source files
------------

// File: rtl/eth_tx_crc_fifo.sv
// Dual-clock show-ahead byte FIFO (wrclk -> GMII_GTXC) plus a byte-wide
// reflected CRC-32 engine that presents the Ethernet FCS in transmit order.
module eth_tx_crc_fifo #(
  parameter int DEPTH = 4096,
  parameter int UW    = 13
) (
  input  logic          GMII_GTXC,
  input  logic          wrclk,
  input  logic          Rst_n,
  input  logic          aclr,
  input  logic          wrreq,
  input  logic [7:0]    wrdata,
  output logic [UW-1:0] wrusedw,
  output logic          wrfull,
  input  logic          rdreq,
  output logic [7:0]    q,
  output logic [UW-1:0] rdusedw,
  output logic          rdempty,
  input  logic          Reset,
  input  logic          Enable,
  input  logic [7:0]    Data_in,
  output logic [31:0]   Crc,
  output logic [31:0]   CrcNext,
  output logic [31:0]   Crc_eth
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [31:0] POLY = 32'hEDB88320;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Either reset source empties the FIFO immediately in both domains.
  logic fifo_rst_n;
  assign fifo_rst_n = Rst_n & ~aclr;

  logic [7:0] mem [DEPTH];

  // ---------------- write domain ----------------
  logic [PW-1:0] wptr_q, wptr_d, wgray_q;
  logic [PW-1:0] rgray_s1_q, rgray_s2_q;
  logic [PW-1:0] rptr_wsync, wdiff;
  logic          wr_en;

  assign rptr_wsync = gray2bin(rgray_s2_q);
  assign wdiff      = wptr_q - rptr_wsync;
  assign wrfull     = (wdiff == PW'(DEPTH));
  assign wrusedw    = UW'(wdiff);
  assign wr_en      = wrreq & ~wrfull;
  assign wptr_d     = wptr_q + PW'(wr_en);

  always_ff @(posedge wrclk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      wptr_q     <= '0;
      wgray_q    <= '0;
      rgray_s1_q <= '0;
      rgray_s2_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      wgray_q    <= bin2gray(wptr_d);
      rgray_s1_q <= rgray_q;
      rgray_s2_q <= rgray_s1_q;
    end
  end

  always_ff @(posedge wrclk) begin
    if (wr_en) begin
      mem[wptr_q[AW-1:0]] <= wrdata;
    end
  end

  // ---------------- read domain ----------------
  logic [PW-1:0] rptr_q, rptr_d, rgray_q;
  logic [PW-1:0] wgray_s1_q, wgray_s2_q;
  logic [PW-1:0] wptr_rsync, rdiff;
  logic [7:0]    q_q;
  logic          rdempty_q, rdempty_d;
  logic          rd_en;

  assign wptr_rsync = gray2bin(wgray_s2_q);
  assign rdiff      = wptr_rsync - rptr_q;
  assign rdusedw    = UW'(rdiff);
  assign rd_en      = rdreq & ~rdempty_q;
  assign rptr_d     = rptr_q + PW'(rd_en);
  // The head register is refilled on the same edge the flag clears, so q is
  // valid whenever rdempty is low; when nothing is left q keeps its value.
  assign rdempty_d  = (rptr_d == wptr_rsync);
  assign rdempty    = rdempty_q;
  assign q          = q_q;

  always_ff @(posedge GMII_GTXC or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      rptr_q     <= '0;
      rgray_q    <= '0;
      wgray_s1_q <= '0;
      wgray_s2_q <= '0;
      rdempty_q  <= 1'b1;
      q_q        <= 8'h00;
    end else begin
      rptr_q     <= rptr_d;
      rgray_q    <= bin2gray(rptr_d);
      wgray_s1_q <= wgray_q;
      wgray_s2_q <= wgray_s1_q;
      rdempty_q  <= rdempty_d;
      if (!rdempty_d) begin
        q_q <= mem[rptr_d[AW-1:0]];
      end
    end
  end

  // ---------------- CRC-32 ----------------
  logic [31:0] crc_q, crc_d, crc_step, crc_sel, crc_inv;

  // Eight LSB-first serial shifts unrolled into one combinational stage.
  always_comb begin
    crc_step = crc_q;
    for (int i = 0; i < 8; i++) begin
      crc_step = {1'b0, crc_step[31:1]} ^ ((crc_step[0] ^ Data_in[i]) ? POLY : 32'h0);
    end
  end

  always_comb begin
    crc_d = crc_q;
    if (Reset) begin
      crc_d = 32'hFFFFFFFF;
    end else if (Enable) begin
      crc_d = crc_step;
    end
  end

  always_ff @(posedge GMII_GTXC or negedge Rst_n) begin
    if (!Rst_n) begin
      crc_q <= 32'hFFFFFFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  // FCS includes the byte currently presented with Enable high.
  assign crc_sel = Enable ? crc_step : crc_q;
  assign crc_inv = ~crc_sel;
  assign Crc     = crc_q;
  assign CrcNext = crc_step;
  assign Crc_eth = {crc_inv[7:0], crc_inv[15:8], crc_inv[23:16], crc_inv[31:24]};

endmodule

// File: tb/tb_eth_tx_crc_fifo.sv
`timescale 1ns/1ps
// Bench for eth_tx_crc_fifo: CRC vector table and random CRC steps against a
// table-driven CRC model, plus FIFO sequences checked against a byte queue.
module tb_eth_tx_crc_fifo;
  localparam int DEPTH = 4096;
  localparam int UW    = 13;

  logic          GMII_GTXC = 1'b0;
  logic          wrclk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          aclr = 1'b0;
  logic          wrreq = 1'b0;
  logic [7:0]    wrdata = 8'h00;
  logic [UW-1:0] wrusedw;
  logic          wrfull;
  logic          rdreq = 1'b0;
  logic [7:0]    q;
  logic [UW-1:0] rdusedw;
  logic          rdempty;
  logic          Reset = 1'b0;
  logic          Enable = 1'b0;
  logic [7:0]    Data_in = 8'h00;
  logic [31:0]   Crc, CrcNext, Crc_eth;

  eth_tx_crc_fifo #(.DEPTH(DEPTH), .UW(UW)) dut (
    .GMII_GTXC(GMII_GTXC), .wrclk(wrclk), .Rst_n(Rst_n), .aclr(aclr),
    .wrreq(wrreq), .wrdata(wrdata), .wrusedw(wrusedw), .wrfull(wrfull),
    .rdreq(rdreq), .q(q), .rdusedw(rdusedw), .rdempty(rdempty),
    .Reset(Reset), .Enable(Enable), .Data_in(Data_in),
    .Crc(Crc), .CrcNext(CrcNext), .Crc_eth(Crc_eth)
  );

  always #5 GMII_GTXC = ~GMII_GTXC;  // 100 MHz
  always #4 wrclk = ~wrclk;          // 125 MHz

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst;
    logic        en;
    logic [7:0]  d;
    logic        chk_eth;
    logic [31:0] exp_eth;
    logic        chk_crc;
    logic [31:0] exp_crc;
  } crc_vec_t;

  crc_vec_t    vecs[$];
  logic [31:0] crc_tbl [256];
  logic [31:0] m_crc = 32'hFFFFFFFF;
  logic [7:0]  fq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_le(input string name, input int act, input int bound);
    n_checks++;
    if (act > bound) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected at most %0d at %0t", name, act, bound, $time);
    end
  endtask

  function automatic logic [31:0] tbl_upd(input logic [31:0] c, input logic [7:0] d);
    return (c >> 8) ^ crc_tbl[c[7:0] ^ d];
  endfunction

  function automatic logic [31:0] fcs_of(input logic [31:0] s);
    logic [31:0] c;
    c = ~s;
    return {c[7:0], c[15:8], c[23:16], c[31:24]};
  endfunction

  task automatic add_vec(input logic rst, input logic en, input logic [7:0] d,
                         input logic ce, input logic [31:0] ee,
                         input logic cc, input logic [31:0] ec);
    crc_vec_t v;
    v.rst = rst; v.en = en; v.d = d;
    v.chk_eth = ce; v.exp_eth = ee; v.chk_crc = cc; v.exp_crc = ec;
    vecs.push_back(v);
  endtask

  task automatic apply_crc(input crc_vec_t v);
    logic [31:0] exp_next;
    @(negedge GMII_GTXC);
    Reset = v.rst; Enable = v.en; Data_in = v.d;
    #1;
    exp_next = tbl_upd(m_crc, v.d);
    check("CrcNext", CrcNext, exp_next);
    check("Crc_eth", Crc_eth, fcs_of(v.en ? exp_next : m_crc));
    if (v.chk_eth) check("Crc_eth_ref", Crc_eth, v.exp_eth);
    @(posedge GMII_GTXC);
    if (v.rst) m_crc = 32'hFFFFFFFF;
    else if (v.en) m_crc = exp_next;
    #1;
    check("Crc", Crc, m_crc);
    if (v.chk_crc) check("Crc_ref", Crc, v.exp_crc);
    $display("crc rst=%0b en=%0b d=%02h crc=%08h eth=%08h", v.rst, v.en, v.d, Crc, Crc_eth);
  endtask

  task automatic wr_burst(input int n, input bit rnd, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      @(negedge wrclk);
      wrreq = 1'b1;
      wrdata = rnd ? 8'($urandom) : base + 8'(k);
      @(posedge wrclk);
      fq.push_back(wrdata);
    end
    @(negedge wrclk);
    wrreq = 1'b0;
  endtask

  task automatic fifo_read(input int n, input bit verbose);
    int waited;
    logic [7:0] exp;
    @(negedge GMII_GTXC);
    for (int k = 0; k < n; k++) begin
      waited = 0;
      while (rdempty && waited < 50) begin
        @(negedge GMII_GTXC);
        waited++;
      end
      check("rd_ready", rdempty, 1'b0);
      if (rdempty) break;
      exp = fq.pop_front();
      check("rd_q", q, exp);
      if (verbose) $display("read q=%02h expected=%02h", q, exp);
      rdreq = 1'b1;
      @(negedge GMII_GTXC);
      rdreq = 1'b0;
    end
  endtask

  task automatic gtx_wait(input int n);
    repeat (n) @(negedge GMII_GTXC);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    crc_vec_t    v;
    int          edges;

    for (int i = 0; i < 256; i++) begin
      r = 32'(i);
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      crc_tbl[i] = r;
    end

    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFF);
    for (int i = 0; i < 8; i++) add_vec(1'b0, 1'b1, 8'h31 + 8'(i), 1'b0, 32'h0, 1'b0, 32'h0);
    add_vec(1'b0, 1'b1, 8'h39, 1'b1, 32'h2639F4CB, 1'b1, 32'h340BC6D9);
    add_vec(1'b0, 1'b0, 8'hAA, 1'b1, 32'h2639F4CB, 1'b1, 32'h340BC6D9);
    add_vec(1'b0, 1'b1, 8'h26, 1'b0, 32'h0, 1'b0, 32'h0);
    add_vec(1'b0, 1'b1, 8'h39, 1'b0, 32'h0, 1'b0, 32'h0);
    add_vec(1'b0, 1'b1, 8'hF4, 1'b0, 32'h0, 1'b0, 32'h0);
    add_vec(1'b0, 1'b1, 8'hCB, 1'b0, 32'h0, 1'b1, 32'hDEBB20E3);
    add_vec(1'b0, 1'b1, 8'h55, 1'b0, 32'h0, 1'b0, 32'h0);
    add_vec(1'b1, 1'b1, 8'h77, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFF);
    add_vec(1'b0, 1'b0, 8'h12, 1'b1, 32'h00000000, 1'b1, 32'hFFFFFFFF);

    // Reset state
    repeat (3) @(negedge GMII_GTXC);
    check("rst_Crc", Crc, 32'hFFFFFFFF);
    check("rst_rdusedw", rdusedw, 0);
    check("rst_wrusedw", wrusedw, 0);
    check("rst_rdempty", rdempty, 1'b1);
    check("rst_wrfull", wrfull, 1'b0);
    check("rst_q", q, 8'h00);
    Rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply_crc(vecs[i]);

    for (int i = 0; i < 300; i++) begin
      v.rst = ($urandom_range(15) == 0);
      v.en = 1'($urandom_range(1));
      v.d = 8'($urandom);
      v.chk_eth = 1'b0; v.exp_eth = 32'h0; v.chk_crc = 1'b0; v.exp_crc = 32'h0;
      apply_crc(v);
    end
    @(negedge GMII_GTXC);
    Reset = 1'b0; Enable = 1'b0;

    // Ordered transfer of 0x00..0x0F
    @(negedge wrclk);
    wrreq = 1'b1; wrdata = 8'h00;
    @(posedge wrclk);
    fq.push_back(8'h00);
    #1;
    wrreq = 1'b0;
    check("wrusedw_first", wrusedw, 1);
    edges = 0;
    while (rdempty && edges < 3) begin
      @(posedge GMII_GTXC);
      #1;
      edges++;
    end
    check("rdempty_fall", rdempty, 1'b0);
    check("q_showahead", q, 8'h00);
    wr_burst(15, 1'b0, 8'h01);
    gtx_wait(6);
    check("rdusedw_16", rdusedw, 16);
    check("wrusedw_16", wrusedw, 16);
    fifo_read(16, 1'b1);
    check("rdempty_drained", rdempty, 1'b1);
    check("rdusedw_drained", rdusedw, 0);

    // Read attempts while empty must not disturb anything
    rdreq = 1'b1;
    gtx_wait(2);
    rdreq = 1'b0;
    check("rd_empty_ignored_used", rdusedw, 0);
    check("rd_empty_ignored_flag", rdempty, 1'b1);

    // Fill to DEPTH, then one ignored write
    wr_burst(DEPTH, 1'b1, 8'h00);
    check("fill_wrfull", wrfull, 1'b1);
    check("fill_wrusedw", wrusedw, DEPTH);
    wrreq = 1'b1; wrdata = 8'hA5;
    @(posedge wrclk);
    #1;
    wrreq = 1'b0;
    check("overflow_wrfull", wrfull, 1'b1);
    check("overflow_wrusedw", wrusedw, DEPTH);
    gtx_wait(6);
    check("fill_rdusedw", rdusedw, DEPTH);
    $display("fill: %0d bytes buffered, reading back", DEPTH);
    fifo_read(DEPTH, 1'b0);
    gtx_wait(6);
    check("fill_rdempty", rdempty, 1'b1);
    check("fill_rdusedw_end", rdusedw, 0);
    check("fill_wrusedw_end", wrusedw, 0);
    check("fill_wrfull_end", wrfull, 1'b0);

    // Randomized concurrent traffic
    fork
      begin
        @(negedge wrclk);
        for (int k = 0; k < 400; k++) begin
          wrreq = 1'b1;
          wrdata = 8'($urandom);
          @(posedge wrclk);
          fq.push_back(wrdata);
          @(negedge wrclk);
          wrreq = 1'b0;
          repeat ($urandom_range(0, 2)) @(negedge wrclk);
        end
      end
      begin
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < 400 && cyc < 20000) begin
          @(negedge GMII_GTXC);
          cyc++;
          rdreq = 1'b0;
          check_le("rand_rdusedw_bound", int'(rdusedw), fq.size());
          if (!rdempty && $urandom_range(1) == 1) begin
            check("rand_q", q, fq.pop_front());
            rdreq = 1'b1;
            got++;
          end
        end
        @(negedge GMII_GTXC);
        rdreq = 1'b0;
        check("rand_count", got, 400);
        $display("random: %0d bytes transferred in %0d read cycles", got, cyc);
      end
    join

    // aclr with 100 bytes buffered
    wr_burst(100, 1'b1, 8'h00);
    gtx_wait(6);
    check("pre_aclr_rdusedw", rdusedw, 100);
    #2;
    aclr = 1'b1;
    #1;
    check("aclr_rdusedw", rdusedw, 0);
    check("aclr_wrusedw", wrusedw, 0);
    check("aclr_rdempty", rdempty, 1'b1);
    check("aclr_wrfull", wrfull, 1'b0);
    check("aclr_Crc", Crc, m_crc);
    @(negedge GMII_GTXC);
    aclr = 1'b0;
    fq.delete();
    $display("aclr: FIFO cleared, Crc=%08h", Crc);
    wr_burst(3, 1'b1, 8'h00);
    fifo_read(3, 1'b1);

    // Rst_n mid-operation
    @(negedge GMII_GTXC);
    Enable = 1'b1; Data_in = 8'h5A;
    @(posedge GMII_GTXC);
    m_crc = tbl_upd(m_crc, 8'h5A);
    #1;
    Enable = 1'b0;
    wr_burst(5, 1'b1, 8'h00);
    gtx_wait(6);
    check("pre_rst_Crc", Crc, m_crc);
    #2;
    Rst_n = 1'b0;
    #1;
    check("midrst_Crc", Crc, 32'hFFFFFFFF);
    check("midrst_rdempty", rdempty, 1'b1);
    check("midrst_q", q, 8'h00);
    check("midrst_wrusedw", wrusedw, 0);
    @(negedge GMII_GTXC);
    Rst_n = 1'b1;
    m_crc = 32'hFFFFFFFF;
    fq.delete();
    wr_burst(4, 1'b0, 8'hC0);
    fifo_read(4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
